fp_square_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision squarer; the inverse of the FP square-root unit. Computes result = A*A.
- Used to re-square sqrt outputs for self-check and as the x^2 primitive for FP datapath ops.
- Iterative shift-add mantissa multiplier behind a valid/ready handshake on both sides.
- Flag outputs match the sqrt unit's style: overflow, underflow, exception.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_round_norm.sv | 47 ++++
 rtl/fp_square_seq.sv | 140 ++++++++++++++
 tb/tb_fp_square_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, FSM state type and operand classifiers
// for the sequential floating-point arithmetic blocks.
package fp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF    = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_nan(input logic [31:0] a);
    return (a[30:23] == 8'(FP_EXP_MAX)) && (a[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] a);
    return (a[30:23] == 8'(FP_EXP_MAX)) && (a[22:0] == 23'd0);
  endfunction

  // Denormals are flushed, so they classify together with zero.
  function automatic logic is_zero_or_denorm(input logic [31:0] a);
    return a[30:23] == 8'd0;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalise + round-to-nearest-even for a 48-bit mantissa product of two
// operands sharing biased exponent i_e; saturates to +Inf or flushes to zero.
module fp_round_norm
  import fp_pkg::*;
(
  input  logic [47:0] i_p,
  input  logic [7:0]  i_e,
  output logic [31:0] o_result,
  output logic        o_overflow,
  output logic        o_underflow
);

  logic               w_hi;
  logic [22:0]        w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_inc;
  logic [23:0]        w_rounded;
  logic               w_carry;
  logic signed [9:0]  w_er;

  // NOTE: every signal driven here gets a value on every path before any
  // conditional override, otherwise synthesis infers latches.
  always_comb begin
    w_hi        = i_p[47];
    w_mant      = w_hi ? i_p[46:24] : i_p[45:23];
    w_guard     = w_hi ? i_p[23]    : i_p[22];
    w_sticky    = w_hi ? (|i_p[22:0]) : (|i_p[21:0]);
    w_inc       = w_guard & (w_sticky | w_mant[0]);
    w_rounded   = {1'b0, w_mant} + {23'd0, w_inc};
    // An all-ones mantissa rounding up leaves zeros in w_rounded[22:0] already.
    w_carry     = w_rounded[23];
    w_er        = 10'({1'b0, i_e, 1'b0}) - 10'(FP_BIAS) + 10'(w_hi) + 10'(w_carry);

    o_result    = {1'b0, w_er[7:0], w_rounded[22:0]};
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (w_er >= 10'sd255) begin
      o_result   = FP_PINF;
      o_overflow = 1'b1;
    end else if (w_er <= 10'sd0) begin
      o_result    = 32'd0;
      o_underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_square_seq.sv
// Multi-cycle IEEE-754 single-precision squarer: iterative shift-add mantissa multiply,
// then normalise/round, behind valid/ready handshakes on input and output.
module fp_square_seq
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        exception
);

  localparam int         STEPS     = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] STEP_LAST = 5'(STEPS - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_e;
  logic [47:0] r_mcand;
  logic [23:0] r_mplier;
  logic [47:0] r_acc;
  logic [4:0]  r_step;
  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_unf;
  logic        r_exc;
  logic        r_out_valid;

  logic        w_special;
  logic        w_out_fire;
  logic [47:0] w_pp;
  logic [31:0] w_rn_result;
  logic        w_rn_ovf;
  logic        w_rn_unf;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;
  assign exception  = r_exc;
  assign w_special  = is_zero_or_denorm(A) | is_nan(A) | is_inf(A);
  assign w_out_fire = r_out_valid & out_ready;

  // Partial product for the multiplier bits retired this cycle; r_mcand is pre-shifted.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
    end
  end

  fp_round_norm u_round_norm (
    .i_p         (r_acc),
    .i_e         (r_e),
    .o_result    (w_rn_result),
    .o_overflow  (w_rn_ovf),
    .o_underflow (w_rn_unf)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = w_special ? DONE : MUL;
      MUL:     if (r_step == STEP_LAST) w_state_next = NORM;
      NORM:    w_state_next = DONE;
      DONE:    if (w_out_fire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  // NOTE: every register, the datapath included, is cleared by reset so an aborted
  // operation leaves no residue visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_e         <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_step      <= '0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_exc       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_e      <= A[30:23];
            r_mcand  <= {24'd0, 1'b1, A[22:0]};
            r_mplier <= {1'b1, A[22:0]};
            r_acc    <= '0;
            r_step   <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_exc    <= is_nan(A);
            if (is_nan(A))      r_result <= FP_QNAN;
            else if (is_inf(A)) r_result <= FP_PINF;
            else                r_result <= 32'd0;
          end
        end
        MUL: begin
          r_acc    <= r_acc + w_pp;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_step   <= r_step + 5'd1;
        end
        NORM: begin
          r_result <= w_rn_result;
          r_ovf    <= w_rn_ovf;
          r_unf    <= w_rn_unf;
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE and drops on the handshake.
          r_out_valid <= ~w_out_fire;
          if (w_out_fire) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_exc <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_square_seq.sv
// Directed self-checking bench for fp_square_seq: vector table plus hand sequences for
// backpressure, back-to-back operands, reset abort and the 4-bit-per-cycle variant.
module tb_fp_square_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = 32'd0;
  logic        in_ready, out_valid, overflow, underflow, exception;
  logic [31:0] result;

  logic        in_valid4 = 1'b0;
  logic        out_ready4 = 1'b1;
  logic [31:0] a4 = 32'd0;
  logic        in_ready4, out_valid4, overflow4, underflow4, exception4;
  logic [31:0] result4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_square_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .exception(exception)
  );

  fp_square_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .A(a4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .overflow(overflow4), .underflow(underflow4), .exception(exception4)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] res;
    logic [2:0]  flg;   // {overflow, underflow, exception}
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for out_valid; lat counts rising edges after the accept edge.
  task automatic wait_valid(output int lat, output int ready_seen);
    lat = -1;
    ready_seen = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) ready_seen++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic apply(input logic [31:0] av, output int lat, output int ready_seen);
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat, ready_seen);
  endtask

  initial begin
    int lat, rs, stable_bad;

    vecs[0] = '{"three",      32'h4040_0000, 32'h4110_0000, 3'b000, 26};
    vecs[1] = '{"sticky",     32'h3F80_0001, 32'h3F80_0002, 3'b000, 26};
    vecs[2] = '{"tie_even",   32'h3F80_0800, 32'h3F80_1000, 3'b000, 26};
    vecs[3] = '{"max_mant",   32'h3FFF_FFFF, 32'h407F_FFFE, 3'b000, 26};
    vecs[4] = '{"overflow",   32'h60AD_78EC, 32'h7F80_0000, 3'b100, 26};
    vecs[5] = '{"underflow",  32'h1F80_0000, 32'h0000_0000, 3'b010, 26};
    vecs[6] = '{"nan",        32'h7FA0_0000, 32'h7FC0_0000, 3'b001, 1};
    vecs[7] = '{"neg_inf",    32'hFF80_0000, 32'h7F80_0000, 3'b000, 1};
    vecs[8] = '{"denorm",     32'h0000_0001, 32'h0000_0000, 3'b000, 1};

    #1;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result, 32'd0);
    check("rst_flags",     {29'd0, overflow, underflow, exception}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].a, lat, rs);
      check({vecs[i].name, "_lat"},    lat, vecs[i].lat);
      check({vecs[i].name, "_result"}, result, vecs[i].res);
      check({vecs[i].name, "_flags"},  {29'd0, overflow, underflow, exception}, {29'd0, vecs[i].flg});
      check({vecs[i].name, "_busy"},   rs, 0);
      @(negedge clk);
      check({vecs[i].name, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
    end

    // Back-to-back operands with output backpressure; 1.5 is held on the input while busy.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'hC000_0000;
    @(posedge clk);
    #1 a = 32'h3FC0_0000;
    wait_valid(lat, rs);
    check("b2b_first_lat",    lat, 26);
    check("b2b_first_result", result, 32'h4080_0000);
    check("b2b_first_busy",   rs, 0);
    stable_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (result !== 32'h4080_0000 || !out_valid || in_ready) stable_bad++;
    end
    check("b2b_hold_stable", stable_bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_after_hs", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat, rs);
    check("b2b_second_lat",    lat, 26);
    check("b2b_second_result", result, 32'h4010_0000);
    check("b2b_second_flags",  {29'd0, overflow, underflow, exception}, 32'd0);
    @(negedge clk);

    // Reset mid-MUL aborts the operation, then a fresh operation completes normally.
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h4040_0000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h4040_0000, lat, rs);
    check("after_abort_lat",    lat, 26);
    check("after_abort_result", result, 32'h4110_0000);
    @(negedge clk);

    // Four multiplier bits per cycle: 6 MUL cycles.
    @(negedge clk);
    in_valid4 = 1'b1;
    a4 = 32'h4040_0000;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    lat = -1;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid4) break;
    end
    check("bpc4_lat",    lat, 8);
    check("bpc4_result", result4, 32'h4110_0000);
    check("bpc4_flags",  {29'd0, overflow4, underflow4, exception4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
